// File: rtl/addsub_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one HALF_W-bit add/sub datapath between
// two requesters; each DATA_W op runs as a low pass then a high pass with chained carry.
module addsub_share_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_ovf,
  output logic              rsp_zero
);
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  // Handshake: a request is accepted on a rising edge where valid && ready; the
  // response is consumed on a rising edge where rsp_valid && rsp_ready.
  state_t            state;
  logic              last_grant;
  logic              grant;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              sub_q;
  logic              id_q;
  logic [HALF_W-1:0] lo_q;
  logic              c_lo_q;

  logic [DATA_W-1:0] b_eff;
  logic [HALF_W-1:0] add_x;
  logic [HALF_W-1:0] add_y;
  logic              add_cin;
  logic [HALF_W:0]   add_sum;
  logic [DATA_W-1:0] full_res;

  // Round robin only matters when both ask; a lone requester always wins.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && grant;

  assign b_eff = sub_q ? ~b_q : b_q;

  always_comb begin
    add_x   = a_q[HALF_W-1:0];
    add_y   = b_eff[HALF_W-1:0];
    add_cin = sub_q;
    if (state == HI) begin
      add_x   = a_q[DATA_W-1:HALF_W];
      add_y   = b_eff[DATA_W-1:HALF_W];
      add_cin = c_lo_q;
    end
  end

  // The one shared adder, used by both passes.
  assign add_sum  = {1'b0, add_x} + {1'b0, add_y} + {{HALF_W{1'b0}}, add_cin};
  assign full_res = {add_sum[HALF_W-1:0], lo_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      id_q       <= 1'b0;
      lo_q       <= '0;
      c_lo_q     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a_q        <= grant ? req1_a : req0_a;
            b_q        <= grant ? req1_b : req0_b;
            sub_q      <= grant ? req1_sub : req0_sub;
            id_q       <= grant;
            last_grant <= grant;
            state      <= LO;
          end
        end
        LO: begin
          lo_q   <= add_sum[HALF_W-1:0];
          c_lo_q <= add_sum[HALF_W];
          state  <= HI;
        end
        HI: begin
          rsp_result <= full_res;
          rsp_carry  <= add_sum[HALF_W];
          rsp_ovf    <= (a_q[DATA_W-1] == b_eff[DATA_W-1]) &&
                        (full_res[DATA_W-1] != a_q[DATA_W-1]);
          rsp_zero   <= (full_res == '0);
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl: directed vector table, random ops against an arithmetic
// model, round-robin, backpressure and mid-operation reset sequences.
module tb_addsub_share_ctrl;
  localparam int W  = 32;
  localparam int EW = W + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_zero;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  addsub_share_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         carry;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Packed as {id, carry, ovf, zero, result}; computed from plain signed/unsigned arithmetic.
  function automatic logic [EW-1:0] model(input logic id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic sub);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint st;
    logic [W-1:0] r;
    logic c, o;
    r  = sub ? a - b : a + b;
    c  = sub ? (ua >= ub) : (((ua + ub) >> W) != 0);
    st = sub ? sa - sb : sa + sb;
    o  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return {id, c, o, (r == '0), r};
  endfunction

  function automatic logic [EW-1:0] rsp_now();
    return {rsp_id, rsp_carry, rsp_ovf, rsp_zero, rsp_result};
  endfunction

  task automatic set_req(input logic id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub; end
  endtask

  task automatic score(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 64'(rsp_now()), 64'hdead);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(rsp_now()), 64'(e));
    end
  endtask

  // Called at a negedge; returns at a negedge with the op fully drained.
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [EW-1:0] exp, input int hold,
                       input string name);
    int n = 0;
    logic [EW-1:0] snap;
    exp_q.push_back(exp);
    set_req(id, 1'b1, a, b, sub);
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      check({name, "_accept_timeout"}, 64'd0, 64'd1);
      set_req(id, 1'b0, a, b, sub);
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, sub);
    @(negedge clk); check({name, "_lat_lo"}, 64'(rsp_valid), 64'd0);
    @(negedge clk); check({name, "_lat_hi"}, 64'(rsp_valid), 64'd0);
    @(negedge clk); check({name, "_lat_valid"}, 64'(rsp_valid), 64'd1);
    snap = rsp_now();
    score(name);
    if (hold > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_stable"}, 64'({rsp_valid, rsp_now()}), 64'({1'b1, snap}));
      check({name, "_hold_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    check({name, "_flags_keep"}, 64'(rsp_now() & ~({1'b1, {(EW-1){1'b0}}})),
          64'(snap & ~({1'b1, {(EW-1){1'b0}}})));
    if (hold > 0) begin
      #1;
      check({name, "_idle_after"}, 64'(req0_ready || req1_ready), 64'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic [W-1:0] ra, rb;
    logic rid, rsub, g;
    int grants, rsps, cyc;

    vecs[0] = '{1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'd40968,    32'd1174,     1'b1, 32'd39794,    1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 32'h0001FFFF, 32'h0000FFFF, 1'b1, 32'h00010000, 1'b1, 1'b0, 1'b0};

    // Reset state, with both requesters asking to prove ready stays low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset_ready", 64'({req0_ready, req1_ready}), 64'd0);
    check("reset_rsp", 64'({rsp_valid, rsp_now()}), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub,
            {vecs[i].id, vecs[i].carry, vecs[i].ovf, vecs[i].zero, vecs[i].res}, 0, "vec");

    do_op(1'b0, 32'h00000003, 32'h00000004, 1'b0, model(1'b0, 32'h3, 32'h4, 1'b0), 5, "backpressure");

    for (int i = 0; i < 20; i++) begin
      rid = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      ra = $urandom(); rb = $urandom();
      if (i % 5 == 0) rb = ra;
      do_op(rid, ra, rb, rsub, model(rid, ra, rb, rsub), int'($urandom_range(0, 2)), "rand");
    end

    // Round robin from a fresh reset: both held valid, expect grants 0,1,0,1.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req0_a = $urandom(); req0_b = $urandom(); req0_sub = 1'b1;
    req1_a = $urandom(); req1_b = $urandom(); req1_sub = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    grants = 0; rsps = 0; cyc = 0;
    while (rsps < 4 && cyc < 200) begin
      if (req0_ready && req1_ready) check("rr_one_ready", 64'd2, 64'd1);
      if ((req0_ready || req1_ready) && grants < 4) begin
        g = req1_ready;
        check("rr_grant", 64'(g), 64'(grants % 2));
        exp_q.push_back(g ? model(1'b1, req1_a, req1_b, req1_sub) : model(1'b0, req0_a, req0_b, req0_sub));
        grants++;
      end
      if (rsp_valid) begin
        score("rr_rsp");
        rsps++;
      end
      @(negedge clk); cyc++;
      if (grants >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
    end
    check("rr_rsp_count", 64'(rsps), 64'd4);
    rsp_ready = 1'b0;
    @(negedge clk);

    // Reset while in HI: op is discarded and requester 0 is granted first afterwards.
    req0_valid = 1'b1; req0_a = 32'h11111111; req0_b = 32'h22222222; req0_sub = 1'b0;
    #1;
    check("mid_rst_accept", 64'(req0_ready), 64'd1);
    @(posedge clk); #1; req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rsp", 64'({rsp_valid, rsp_now()}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", 64'({rsp_valid, rsp_now()}), 64'd0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_rst_grant0", 64'({req0_ready, req1_ready}), 64'b10);
    req1_valid = 1'b0;
    do_op(1'b0, 32'h11111111, 32'h22222222, 1'b0, model(1'b0, 32'h11111111, 32'h22222222, 1'b0),
          0, "post_rst");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
